l0_skew_buffer: RTL
===================

L0_SKEW_BUFFER -- requirements
Module: l0_skew_buffer

Interface
REQ-001 SHALL have parameter ROW, default 8, number of row lanes.
REQ-002 SHALL have parameter BW, default 4, bits per lane element.
REQ-003 SHALL have parameter DEPTH, default 64, entries per lane; power of 2, >=2.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in  input  ROW*BW  write vector; lane i = in[BW*(i+1)-1:BW*i].
REQ-007 SHALL have port wr  input  1  write request, all lanes in lockstep.
REQ-008 SHALL have port rd  input  1  read request.
REQ-009 SHALL have port mode  input  1  read mode: 0 = parallel (all lanes), 1 = skewed (diagonal wavefront).
REQ-010 SHALL have port out  output  ROW*BW  registered read data, same lane packing as in.
REQ-011 SHALL have port out_valid  output  ROW  per-lane one-cycle pulse; out lane i is new data.
REQ-012 SHALL have port o_full  output  1  at least one lane holds DEPTH entries.
REQ-013 SHALL have port o_ready  output  1  equal to ~o_full; a write will be accepted.
REQ-014 SHALL have port o_empty  output  1  all lanes hold 0 entries.
REQ-015 SHALL have port o_count  output  log2(DEPTH)+1  occupancy of lane 0.

Function
REQ-016 SHALL store data in per-lane circular buffers with one shared write pointer and one read pointer per lane; pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-017 SHALL accept a write when wr=1 and o_ready=1: all lanes store their in slice, shared write pointer +1; wr with o_ready=0 ignored, no state change.
REQ-018 SHALL hold an internal mode_q that loads mode only while no skewed read is in flight (skew pipe stages 1..ROW-1 all 0); otherwise mode_q holds.
REQ-019 SHALL in mode_q=0 accept rd only when every lane is non-empty; an accepted rd reads all lanes in the same cycle.
REQ-020 SHALL in mode_q=1 accept rd only when lane 0 is non-empty; accepted rd enters a ROW-stage skew pipe; lane i reads i cycles after acceptance.
REQ-021 SHALL guarantee occupancy(lane i) >= occupancy(lane 0) in mode 1, so a delayed lane read never underflows; a lane read on an empty lane SHALL be suppressed (defensive).
REQ-022 SHALL register read data: lane i out and out_valid[i] update the cycle after lane i's read; latency rd->out_valid[0] = 1 cycle, lane i in mode 1 = i+1 cycles.
REQ-023 SHALL hold out lanes at last value when not read; out_valid[i]=0 in cycles without a lane-i read.
REQ-024 SHALL accept back-to-back rd every cycle in either mode; mode 1 sustains one wavefront per cycle.
REQ-025 SHALL evaluate acceptance from pre-edge occupancy: rd+wr on an empty lane set writes only; rd+wr on full accepts rd only; rd+wr otherwise accepts both, occupancy unchanged.
REQ-026 SHALL compute o_full, o_empty, o_count combinationally from pointers/occupancy counters, reflecting state after the last edge.
REQ-027 SHALL ignore rd when not accepted; no pointer, pipe, or out change.

Reset
REQ-028 SHALL on reset clear all pointers and occupancy, skew pipe, mode_q (to 0), out (to 0), out_valid (to 0); o_empty=1, o_full=0, o_ready=1, o_count=0 the following cycle.
REQ-029 SHALL on reset mid-operation discard stored data and all in-flight skewed reads; no out_valid pulse after the reset edge.
REQ-030 SHALL give reset priority over wr and rd in the same cycle.

Verification
REQ-031 SHALL cover parallel: write 3 vectors (lane i = i, i+1, i+2), mode=0, rd x3 -> out_valid=8'hFF for 3 cycles, lanes i,i+1,i+2 in order; o_empty=1 after.
REQ-032 SHALL cover skewed: write 1 vector lane i = i, mode=1, one rd -> out_valid[i] pulses exactly cycle i+1, out lane i = i; o_empty=1 after lane 7 read.
REQ-033 SHALL cover full/wrap: write 64 vectors -> o_full=1, o_ready=0, o_count=64; 65th wr ignored; read 64 then write/read 10 more -> data order preserved across pointer wrap.
REQ-034 SHALL cover simultaneous: rd+wr on empty -> no out_valid, o_count=1; rd+wr at o_count=64 -> read accepted, o_count=63.
REQ-035 SHALL cover mode switch: mode=1 rd then mode=0 next cycle -> mode_q stays 1 until lane 7 read completes, then parallel reads resume.
REQ-036 SHALL cover mid-skew reset: 4 skewed rds, reset at cycle 3 -> no out_valid after reset, o_empty=1, o_count=0.

Source files
------------

// File: rtl/l0_skew_buffer.sv
// rtl/l0_skew_buffer.sv - per-lane circular buffer with parallel or diagonal (skewed) read-out
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears pointers, occupancy, skew pipe, mode, out
//   in         ROW lanes of BW bits, lane i = in[BW*i +: BW]
//   wr         lockstep write of all lanes, accepted when o_ready
//   rd         read request; acceptance depends on the latched read mode
//   mode       requested read mode: 0 parallel, 1 skewed wavefront
//   out        registered read data, same lane packing as in
//   out_valid  per-lane one-cycle pulse marking new data on that out lane
//   o_full     some lane holds DEPTH entries
//   o_ready    ~o_full
//   o_empty    every lane holds zero entries
//   o_count    occupancy of lane 0
module l0_skew_buffer #(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ROW*BW-1:0]        in,
    input  logic                     wr,
    input  logic                     rd,
    input  logic                     mode,
    output logic [ROW*BW-1:0]        out,
    output logic [ROW-1:0]           out_valid,
    output logic                     o_full,
    output logic                     o_ready,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BW-1:0] mem [ROW][DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr [ROW];
    logic [CW-1:0] cnt  [ROW];
    logic          mode_q;
    // skew_q[k] set: lane k performs its part of a skewed read this cycle
    logic [ROW-1:1] skew_q;

    logic [ROW-1:0] lane_ne;
    logic [ROW-1:0] lane_rd;
    logic           any_full;
    logic           wr_acc;
    logic           rd_acc;
    logic           skew_in;
    logic           in_flight;

    always_comb begin
        any_full = 1'b0;
        lane_ne  = '0;
        for (int i = 0; i < ROW; i++) begin
            lane_ne[i] = (cnt[i] != '0);
            if (cnt[i] == CW'(DEPTH)) any_full = 1'b1;
        end
    end

    assign wr_acc  = wr & ~any_full;
    // Skewed mode only needs lane 0 populated: the other lanes never trail lane 0
    assign rd_acc  = rd & (mode_q ? lane_ne[0] : (&lane_ne));
    assign skew_in = rd_acc & mode_q;
    // A wavefront accepted this cycle also pins the mode, otherwise a parallel
    // read could be accepted next cycle while lanes 1.. are still owed a read.
    assign in_flight = skew_in | (|skew_q);

    always_comb begin
        lane_rd    = '0;
        lane_rd[0] = rd_acc & lane_ne[0];
        for (int i = 1; i < ROW; i++) begin
            // Reads on an empty lane are dropped rather than underflowing
            lane_rd[i] = ((rd_acc & ~mode_q) | skew_q[i]) & lane_ne[i];
        end
    end

    // Storage is not reset; the pointers and occupancy define what is valid
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            for (int i = 0; i < ROW; i++) begin
                mem[i][wptr] <= in[BW*i +: BW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            mode_q    <= 1'b0;
            skew_q    <= '0;
            out       <= '0;
            out_valid <= '0;
            for (int i = 0; i < ROW; i++) begin
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            if (wr_acc) wptr <= wptr + AW'(1);
            for (int i = 0; i < ROW; i++) begin
                if (lane_rd[i]) begin
                    rptr[i]          <= rptr[i] + AW'(1);
                    out[BW*i +: BW]  <= mem[i][rptr[i]];
                end
                cnt[i] <= cnt[i] + CW'(wr_acc) - CW'(lane_rd[i]);
            end
            out_valid <= lane_rd;
            skew_q[1] <= skew_in;
            for (int k = 2; k < ROW; k++) begin
                skew_q[k] <= skew_q[k-1];
            end
            if (!in_flight) mode_q <= mode;
        end
    end

    always_comb begin
        o_full  = any_full;
        o_ready = ~any_full;
        o_empty = ~(|lane_ne);
        o_count = cnt[0];
    end

endmodule
